// File: rtl/lsu.sv
// Load/store unit: one RAM req/ack transaction per accepted request; 3 cycles minimum (accept, req, done).
// Backpressure: stall_o holds the pipeline from acceptance until the RAM ack lands.
module lsu #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid_i,
   input  logic              mem_we_i,
   input  logic [2:0]        funct3_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              flush_i,
   output logic              ram_req_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   output logic [3:0]        ram_wmask_o,
   input  logic              ram_ack_i,
   input  logic [DATA_W-1:0] ram_rdata_i,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              data_valid_o,
   output logic              stall_o,
   output logic              exc_o
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t            state;
   logic              flushed;
   logic [2:0]        lat_funct3;
   logic [1:0]        lat_off;
   logic              illegal_f3;
   logic              misaligned;
   logic              accept;
   logic [3:0]        st_mask;
   logic [DATA_W-1:0] st_data;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DATA_W-1:0] ld_data;

   always_comb begin
      illegal_f3 = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
      misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i == 3'b010) && (addr_i[1:0] != 2'b00));
      exc_o      = (state == IDLE) && req_valid_i && (illegal_f3 || misaligned);
      accept     = (state == IDLE) && req_valid_i && !flush_i && !exc_o;
      stall_o    = accept || (state == REQ);
   end

   // Store lanes: bytes/halves are replicated so the mask alone picks the lane.
   always_comb begin
      st_mask = 4'b1111;
      st_data = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            st_mask = 4'b0001 << addr_i[1:0];
            st_data = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            st_mask = 4'b0011 << {addr_i[1], 1'b0};
            st_data = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = ram_rdata_i[7:0];
      case (lat_off)
         2'd1:    ld_byte = ram_rdata_i[15:8];
         2'd2:    ld_byte = ram_rdata_i[23:16];
         2'd3:    ld_byte = ram_rdata_i[31:24];
         default: ld_byte = ram_rdata_i[7:0];
      endcase
      ld_half = lat_off[1] ? ram_rdata_i[31:16] : ram_rdata_i[15:0];
      case (lat_funct3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = ram_rdata_i;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= IDLE;
         flushed      <= 1'b0;
         lat_funct3   <= 3'b000;
         lat_off      <= 2'b00;
         ram_req_o    <= 1'b0;
         ram_we_o     <= 1'b0;
         ram_addr_o   <= '0;
         ram_wdata_o  <= '0;
         ram_wmask_o  <= 4'b0000;
         mem_data_o   <= '0;
         data_valid_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               data_valid_o <= 1'b0;
               if (accept) begin
                  ram_req_o   <= 1'b1;
                  ram_we_o    <= mem_we_i;
                  ram_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                  ram_wdata_o <= st_data;
                  ram_wmask_o <= mem_we_i ? st_mask : 4'b0000;
                  lat_funct3  <= funct3_i;
                  lat_off     <= addr_i[1:0];
                  flushed     <= 1'b0;
                  state       <= REQ;
               end
            end
            REQ: begin
               // A flush cannot abort the bus cycle; it only suppresses the result.
               if (flush_i)
                  flushed <= 1'b1;
               if (ram_ack_i) begin
                  ram_req_o    <= 1'b0;
                  ram_we_o     <= 1'b0;
                  ram_wmask_o  <= 4'b0000;
                  if (!ram_we_o)
                     mem_data_o <= ld_data;
                  data_valid_o <= !ram_we_o && !flushed && !flush_i;
                  state        <= DONE;
               end
            end
            DONE: begin
               data_valid_o <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: table-driven accesses with a result scoreboard, plus reset/flush corner sequences.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid_i;
   logic        mem_we_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        flush_i;
   logic        ram_req_o;
   logic        ram_we_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic [3:0]  ram_wmask_o;
   logic        ram_ack_i;
   logic [31:0] ram_rdata_i;
   logic [31:0] mem_data_o;
   logic        data_valid_o;
   logic        stall_o;
   logic        exc_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   lsu dut (
      .clk(clk), .rstn(rstn), .req_valid_i(req_valid_i), .mem_we_i(mem_we_i),
      .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i), .flush_i(flush_i),
      .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o), .ram_ack_i(ram_ack_i),
      .ram_rdata_i(ram_rdata_i), .mem_data_o(mem_data_o), .data_valid_o(data_valid_o),
      .stall_o(stall_o), .exc_o(exc_o)
   );

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      logic        flush;
      logic        exp_exc;
      logic [3:0]  exp_mask;
      logic [31:0] exp_wdata;
      logic [31:0] exp_data;
   } vec_t;

   typedef struct {
      logic        valid;
      logic [31:0] data;
   } sb_t;

   vec_t        vecs[15];
   sb_t         sb_q[$];
   logic [31:0] last_load;
   logic        load_known;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      sb_t exp_r;
      sb_t got_r;
      @(negedge clk);
      req_valid_i = 1'b1;
      mem_we_i    = v.we;
      funct3_i    = v.f3;
      addr_i      = v.addr;
      wdata_i     = v.wdata;
      #1;
      chk({v.name, " dv_idle"}, 32'(data_valid_o), 32'd0);
      if (v.exp_exc) begin
         chk({v.name, " exc"}, 32'(exc_o), 32'd1);
         chk({v.name, " exc_stall"}, 32'(stall_o), 32'd0);
         @(negedge clk);
         req_valid_i = 1'b0;
         #1;
         chk({v.name, " exc_noreq"}, 32'(ram_req_o), 32'd0);
         if (load_known) chk({v.name, " exc_hold"}, mem_data_o, last_load);
         @(negedge clk);
         chk({v.name, " exc_noreq2"}, 32'(ram_req_o), 32'd0);
         return;
      end
      chk({v.name, " noexc"}, 32'(exc_o), 32'd0);
      chk({v.name, " stall_n"}, 32'(stall_o), 32'd1);
      exp_r.valid = !v.we && !v.flush;
      exp_r.data  = v.exp_data;
      sb_q.push_back(exp_r);
      // Cycle N+1: request on the bus.
      @(negedge clk);
      chk({v.name, " req"}, 32'(ram_req_o), 32'd1);
      chk({v.name, " stall_n1"}, 32'(stall_o), 32'd1);
      chk({v.name, " we"}, 32'(ram_we_o), 32'(v.we));
      chk({v.name, " addr"}, ram_addr_o, v.addr & 32'hFFFF_FFFC);
      chk({v.name, " mask"}, 32'(ram_wmask_o), 32'(v.exp_mask));
      if (v.we) chk({v.name, " wdata"}, ram_wdata_o, v.exp_wdata);
      if (v.flush) flush_i = 1'b1;
      for (int i = 0; i < v.delay; i++) begin
         @(negedge clk);
         flush_i = 1'b0;
         chk({v.name, " stall_wait"}, 32'(stall_o), 32'd1);
         chk({v.name, " req_wait"}, 32'(ram_req_o), 32'd1);
      end
      ram_ack_i   = 1'b1;
      ram_rdata_i = v.rdata;
      @(negedge clk);
      ram_ack_i   = 1'b0;
      flush_i     = 1'b0;
      ram_rdata_i = 32'h5A5A_5A5A;
      chk({v.name, " done_stall"}, 32'(stall_o), 32'd0);
      chk({v.name, " done_req"}, 32'(ram_req_o), 32'd0);
      if (sb_q.size() == 0) begin
         chk({v.name, " sb_empty"}, 32'd1, 32'd0);
      end else begin
         got_r = sb_q.pop_front();
         chk({v.name, " valid"}, 32'(data_valid_o), 32'(got_r.valid));
         if (got_r.valid) begin
            chk({v.name, " data"}, mem_data_o, got_r.data);
            last_load  = got_r.data;
            load_known = 1'b1;
         end else if (v.we) begin
            if (load_known) chk({v.name, " hold"}, mem_data_o, last_load);
         end else begin
            load_known = 1'b0;
         end
      end
   endtask

   initial begin
      rstn = 1'b0; req_valid_i = 1'b0; mem_we_i = 1'b0; funct3_i = 3'b000;
      addr_i = '0; wdata_i = '0; flush_i = 1'b0; ram_ack_i = 1'b0; ram_rdata_i = '0;
      last_load = '0; load_known = 1'b1;

      //          name     we    f3      addr       wdata         rdata        dly flush exc   mask     exp_wdata     exp_data
      vecs[0]  = '{"lw",   1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hDEADBEEF};
      vecs[1]  = '{"lb",   1'b0, 3'b000, 32'h103, 32'h0,        32'h80123456, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hFFFFFF80};
      vecs[2]  = '{"lbu",  1'b0, 3'b100, 32'h103, 32'h0,        32'h80123456, 1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h00000080};
      vecs[3]  = '{"lh",   1'b0, 3'b001, 32'h102, 32'h0,        32'h80011234, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hFFFF8001};
      vecs[4]  = '{"lhu",  1'b0, 3'b101, 32'h102, 32'h0,        32'h80011234, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h00008001};
      vecs[5]  = '{"sb",   1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0,        0, 1'b0, 1'b0, 4'b0010, 32'hABABABAB, 32'h0};
      vecs[6]  = '{"sh",   1'b1, 3'b001, 32'h202, 32'h1234CDEF, 32'h0,        2, 1'b0, 1'b0, 4'b1100, 32'hCDEFCDEF, 32'h0};
      vecs[7]  = '{"sw",   1'b1, 3'b010, 32'h304, 32'h11223344, 32'h0,        0, 1'b0, 1'b0, 4'b1111, 32'h11223344, 32'h0};
      vecs[8]  = '{"lw_mis", 1'b0, 3'b010, 32'h102, 32'h0,      32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
      vecs[9]  = '{"f3_011", 1'b0, 3'b011, 32'h100, 32'h0,      32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
      vecs[10] = '{"lb1",  1'b0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 2, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000007F};
      vecs[11] = '{"lhu0", 1'b0, 3'b101, 32'h100, 32'h0,        32'hFFFF8765, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h00008765};
      vecs[12] = '{"lh_mis", 1'b0, 3'b001, 32'h101, 32'h0,      32'h0,        0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
      vecs[13] = '{"sb3",  1'b1, 3'b000, 32'h20B, 32'h0000005C, 32'h0,        0, 1'b0, 1'b0, 4'b1000, 32'h5C5C5C5C, 32'h0};
      vecs[14] = '{"lw_fl", 1'b0, 3'b010, 32'h108, 32'h0,       32'hCAFEF00D, 3, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(ram_req_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_dv", 32'(data_valid_o), 32'd0);
      chk("rst_data", mem_data_o, 32'd0);
      chk("rst_mask", 32'(ram_wmask_o), 32'd0);
      rstn = 1'b1;

      for (int i = 0; i < 15; i++) run_vec(vecs[i]);

      // Flush in IDLE drops the request outright.
      @(negedge clk);
      req_valid_i = 1'b1; mem_we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h400; flush_i = 1'b1;
      #1;
      chk("idle_flush_stall", 32'(stall_o), 32'd0);
      @(negedge clk);
      req_valid_i = 1'b0; flush_i = 1'b0;
      chk("idle_flush_req", 32'(ram_req_o), 32'd0);

      // Reset in REQ, then a stale ack while IDLE.
      @(negedge clk);
      req_valid_i = 1'b1; mem_we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h500; wdata_i = 32'h77777777;
      @(negedge clk);
      chk("mid_req", 32'(ram_req_o), 32'd1);
      rstn = 1'b0; req_valid_i = 1'b0;
      @(negedge clk);
      chk("mid_rst_req", 32'(ram_req_o), 32'd0);
      chk("mid_rst_we", 32'(ram_we_o), 32'd0);
      chk("mid_rst_addr", ram_addr_o, 32'd0);
      chk("mid_rst_wdata", ram_wdata_o, 32'd0);
      chk("mid_rst_stall", 32'(stall_o), 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      ram_ack_i = 1'b1; ram_rdata_i = 32'h12345678;
      @(negedge clk);
      ram_ack_i = 1'b0;
      chk("stale_dv", 32'(data_valid_o), 32'd0);
      chk("stale_data", mem_data_o, 32'd0);
      chk("stale_req", 32'(ram_req_o), 32'd0);
      @(negedge clk);
      chk("stale_dv2", 32'(data_valid_o), 32'd0);
      chk("stale_stall", 32'(stall_o), 32'd0);
      last_load = 32'd0; load_known = 1'b1;

      run_vec(vecs[0]);
      @(negedge clk);
      req_valid_i = 1'b0;
      chk("dv_pulse", 32'(data_valid_o), 32'd0);
      chk("data_hold", mem_data_o, 32'hDEADBEEF);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
